inst_prefetch: RTL and testbench

Parametrised instruction prefetch unit that replaces the single-cycle PC-plus-ROM fetch path. It owns the PC and issues in-order word requests to an instruction memory with a grant/response handshake and variable latency. Returned words are buffered in a DEPTH-entry FIFO and presented to decode with valid/ready. Jumps redirect the PC, flush the FIFO and discard stale in-flight responses.

---
 rtl/inst_prefetch_if.sv | 25 ++
 rtl/inst_prefetch.sv | 117 +++++++++++
 tb/tb_inst_prefetch.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/inst_prefetch_if.sv
// Fetch-side bus bundle: instruction memory request/grant/response and decode valid/ready.
interface inst_prefetch_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              mem_req_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic              mem_gnt_i;
   logic              mem_rvalid_i;
   logic [DATA_W-1:0] mem_rdata_i;
   logic              inst_valid_o;
   logic [DATA_W-1:0] inst_o;
   logic [ADDR_W-1:0] inst_addr_o;
   logic              inst_ready_i;

   modport master (
      output mem_req_o, mem_addr_o, inst_valid_o, inst_o, inst_addr_o,
      input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, inst_ready_i
   );

   modport slave (
      input  mem_req_o, mem_addr_o, inst_valid_o, inst_o, inst_addr_o,
      output mem_gnt_i, mem_rvalid_i, mem_rdata_i, inst_ready_i
   );
endinterface

// File: rtl/inst_prefetch.sv
// Instruction prefetch: PC owner, credit-limited in-order fetch into a DEPTH FIFO; 2-cycle request-to-valid,
// issue stalls when buffered + outstanding reaches DEPTH. IFU_PERF_CNT_EN builds the dropped-response counter.
module inst_prefetch #(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              jump_i,
   input  logic [ADDR_W-1:0] jump_addr_i,
   inst_prefetch_if.master   bus,
   output logic [31:0]       perf_drop_cnt_o
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [CNT_W-1:0]  outst_q, outst_d, drop_q, drop_d, cnt_q, cnt_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
   logic [DATA_W-1:0] dat_q [DEPTH];
   logic [ADDR_W-1:0] adr_q [DEPTH];
   logic [ADDR_W-1:0] tag_q [DEPTH];
   logic              gnt_fire, resp_drop, push, pop;

   assign bus.mem_req_o    = !rst && (({1'b0, cnt_q} + {1'b0, outst_q}) < DEPTH_C) && !jump_i;
   assign bus.mem_addr_o   = pc_q;
   assign bus.inst_valid_o = (cnt_q != '0);
   assign bus.inst_o       = dat_q[rd_ptr_q];
   assign bus.inst_addr_o  = adr_q[rd_ptr_q];

   assign gnt_fire  = bus.mem_req_o && bus.mem_gnt_i;
   assign resp_drop = bus.mem_rvalid_i && (jump_i || (drop_q != '0));
   assign push      = bus.mem_rvalid_i && !resp_drop;
   assign pop       = bus.inst_valid_o && bus.inst_ready_i && !jump_i;

   always_comb begin
      pc_d     = pc_q;
      drop_d   = drop_q;
      cnt_d    = cnt_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      tag_rd_d = tag_rd_q;
      tag_wr_d = tag_wr_q;
      outst_d  = outst_q + CNT_W'(gnt_fire) - CNT_W'(bus.mem_rvalid_i);
      if (gnt_fire) begin
         pc_d     = pc_q + ADDR_W'(4);
         tag_wr_d = tag_wr_q + PTR_W'(1);
      end
      if (bus.mem_rvalid_i) tag_rd_d = tag_rd_q + PTR_W'(1);
      if (jump_i) begin
         // Jump blocks issue, so outst_d already excludes any grant: it is exactly what is still owed.
         pc_d     = jump_addr_i & ~ADDR_W'(3);
         drop_d   = outst_d;
         cnt_d    = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
      end else begin
         if (resp_drop) drop_d = drop_q - CNT_W'(1);
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
         cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q     <= RESET_PC;
         outst_q  <= '0;
         drop_q   <= '0;
         cnt_q    <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         tag_rd_q <= '0;
         tag_wr_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            dat_q[i] <= '0;
            adr_q[i] <= '0;
            tag_q[i] <= '0;
         end
      end else begin
         pc_q     <= pc_d;
         outst_q  <= outst_d;
         drop_q   <= drop_d;
         cnt_q    <= cnt_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         tag_rd_q <= tag_rd_d;
         tag_wr_q <= tag_wr_d;
         if (gnt_fire) tag_q[tag_wr_q] <= pc_q;
         if (push) begin
            dat_q[wr_ptr_q] <= bus.mem_rdata_i;
            adr_q[wr_ptr_q] <= tag_q[tag_rd_q];
         end
      end
   end

   // Issue credit makes a push into a full FIFO impossible unless the memory misbehaves.
   always_ff @(posedge clk) begin
      if (!rst) assert (!(push && (cnt_q == CNT_W'(DEPTH))));
   end

`ifdef IFU_PERF_CNT_EN
   logic [31:0] perf_q, perf_d;
   assign perf_d = (resp_drop && (perf_q != '1)) ? perf_q + 32'd1 : perf_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) perf_q <= '0;
      else     perf_q <= perf_d;
   end
   assign perf_drop_cnt_o = perf_q;
`else
   assign perf_drop_cnt_o = '0;
`endif
endmodule

// File: tb/tb_inst_prefetch.sv
// Bench for inst_prefetch: variable-latency memory model plus an epoch-based reference of the expected fetch stream.
module tb_inst_prefetch;
   localparam int          ADDR_W   = 32;
   localparam int          DATA_W   = 32;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0;
`ifdef IFU_PERF_CNT_EN
   localparam int PERF_ON = 1;
`else
   localparam int PERF_ON = 0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        jump_i;
   logic [31:0] jump_addr_i;
   logic [31:0] perf;

   inst_prefetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   inst_prefetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk(clk),
      .rst(rst),
      .jump_i(jump_i),
      .jump_addr_i(jump_addr_i),
      .bus(bus),
      .perf_drop_cnt_o(perf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          epoch;
      int          due;
   } req_t;

   req_t        pend[$];   // granted requests the memory still owes, oldest first
   logic [31:0] bufq[$];   // current-stream addresses returned but not yet consumed
   logic [31:0] m_pc;
   int          m_epoch, m_drops, cyc, lat_min, lat_max;
   int          n_cmp, n_fail;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_req"},   64'(bus.mem_req_o),    64'(0));
      check({tag, "_addr"},  64'(bus.mem_addr_o),   64'(RESET_PC));
      check({tag, "_valid"}, 64'(bus.inst_valid_o), 64'(0));
      check({tag, "_inst"},  64'(bus.inst_o),       64'(0));
      check({tag, "_iaddr"}, 64'(bus.inst_addr_o),  64'(0));
      check({tag, "_perf"},  64'(perf),             64'(0));
   endtask

   task automatic model_reset();
      pend.delete();
      bufq.delete();
      m_pc    = RESET_PC;
      m_drops = 0;
   endtask

   // One clock: drive at negedge, compare at negedge+1, advance model, then cross the posedge.
   task automatic step(input bit j, input logic [31:0] ja, input int gnt_pct, input int rdy_pct);
      bit   resp, gnt, rdy, exp_req, pop;
      req_t e;
      @(negedge clk);
      resp = (pend.size() > 0) && (pend[0].due <= cyc);
      gnt  = int'($urandom_range(99)) < gnt_pct;
      rdy  = int'($urandom_range(99)) < rdy_pct;
      bus.mem_rvalid_i = resp;
      bus.mem_rdata_i  = resp ? mem_word(pend[0].addr) : $urandom;
      bus.mem_gnt_i    = gnt;
      bus.inst_ready_i = rdy;
      jump_i           = j;
      jump_addr_i      = ja;
      #1;
      exp_req = !j && ((pend.size() + bufq.size()) < DEPTH);
      check("mem_req",    64'(bus.mem_req_o),    64'(exp_req));
      check("mem_addr",   64'(bus.mem_addr_o),   64'(m_pc));
      check("inst_valid", 64'(bus.inst_valid_o), 64'(bufq.size() > 0));
      if (bufq.size() > 0) begin
         check("inst_addr", 64'(bus.inst_addr_o), 64'(bufq[0]));
         check("inst_data", 64'(bus.inst_o),      64'(mem_word(bufq[0])));
      end
      check("perf_cnt", 64'(perf), 64'(PERF_ON ? m_drops : 0));

      pop = (bufq.size() > 0) && rdy && !j;
      if (pop) void'(bufq.pop_front());
      if (resp) begin
         e = pend.pop_front();
         if (j || (e.epoch != m_epoch)) m_drops++;
         else bufq.push_back(e.addr);
      end
      if (j) begin
         bufq.delete();
         m_epoch++;
         m_pc = ja & ~32'h3;
      end else if (exp_req && gnt) begin
         pend.push_back('{m_pc, m_epoch, cyc + int'($urandom_range(lat_max, lat_min))});
         m_pc = m_pc + 32'd4;
      end
      @(posedge clk);
      cyc++;
   endtask

   task automatic pulse_reset(input string tag);
      @(negedge clk);
      #2;
      rst              = 1'b1;
      bus.mem_rvalid_i = 1'b0;
      bus.mem_gnt_i    = 1'b0;
      jump_i           = 1'b0;
      #1;
      check_reset(tag);
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      n_cmp = 0; n_fail = 0; cyc = 0; m_epoch = 0;
      bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0; bus.inst_ready_i = 1'b0;
      jump_i = 1'b0; jump_addr_i = '0;
      model_reset();
      #1 rst = 1'b1;
      #2;
      check_reset("reset");
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Zero-wait memory, consumer always ready: streaming from RESET_PC.
      lat_min = 1; lat_max = 1;
      repeat (12) step(1'b0, $urandom, 100, 100);
      // Consumer stalls: credit runs out and the request drops.
      repeat (20) step(1'b0, $urandom, 100, 0);
      repeat (8)  step(1'b0, $urandom, 100, 100);

      // Three requests in flight with 3-cycle latency, then redirect (low address bits ignored).
      pulse_reset("rst_a");
      lat_min = 3; lat_max = 3;
      repeat (3) step(1'b0, $urandom, 100, 100);
      step(1'b1, 32'h0000_0103, 100, 100);
      #1 check("jump_target", 64'(bus.mem_addr_o), 64'(32'h100));
      repeat (10) step(1'b0, $urandom, 100, 100);
      check("perf_after_jump", 64'(perf), 64'(PERF_ON ? 3 : 0));

      // Back-to-back jumps with responses in flight; head must come from the second target.
      step(1'b1, 32'h200, 100, 100);
      step(1'b1, 32'h300, 100, 100);
      repeat (8) step(1'b0, $urandom, 100, 0);
      #1 check("b2b_head", 64'(bus.inst_addr_o), 64'(32'h300));
      repeat (10) step(1'b0, $urandom, 100, 100);

      // Grant withheld, then jump while stalled.
      repeat (5) step(1'b0, $urandom, 0, 100);
      step(1'b1, 32'h400, 0, 100);
      #1 check("stall_jump", 64'(bus.mem_addr_o), 64'(32'h400));
      repeat (10) step(1'b0, $urandom, 100, 100);

      // Mid-stream asynchronous reset.
      pulse_reset("rst_b");
      lat_min = 1; lat_max = 1;
      repeat (6) step(1'b0, $urandom, 100, 100);

      // Randomized traffic: variable latency, sporadic grant/ready, occasional jumps.
      lat_min = 1; lat_max = 4;
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(99) < 3), $urandom, 70, 70);
      end
      repeat (12) step(1'b0, $urandom, 0, 100);
      check("idle_owed", 64'(pend.size() == 0), 64'(1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
